// File: rtl/addr_seq_ctrl.sv
// Pattern-address sequencer: steps addr at a programmable rate with start/stop/pause/loop control.
// Each advance is marked by a one-cycle tick clock-enable; no derived clock is generated.
module addr_seq_ctrl #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] ADDR_MAX = 8'd255,
  parameter logic [24:0]       DIV_BASE = 25'd2500,
  parameter int unsigned       CNT_W    = 28
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              pause_i,
  input  logic              loop_en_i,
  input  logic [1:0]        speed_sel_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              tick_o,
  output logic              busy_o,
  output logic              paused_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] DIV_BASE_C = CNT_W'(DIV_BASE);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    counter_q, counter_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                tick_q, tick_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                paused_q, paused_d;
  logic [CNT_W-1:0]    period_new_s;
  logic                at_end_s;
  logic                last_s;

  assign period_new_s = DIV_BASE_C << speed_sel_i;
  assign at_end_s     = (counter_q == (period_q - {{(CNT_W-1){1'b0}}, 1'b1}));
  assign last_s       = (addr_q == ADDR_MAX);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stop outranks pause, which outranks start/count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (stop_i || pause_i) begin
          state_d = ST_IDLE;
        end else if (start_i) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN, ST_PAUSE: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (pause_i) begin
          state_d = ST_PAUSE;
        end else if (at_end_s && last_s && !loop_en_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values; leaving PAUSE counts on the same edge.
  always_comb begin
    counter_d = counter_q;
    period_d  = period_q;
    addr_d    = addr_q;
    tick_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!stop_i && !pause_i && start_i) begin
          addr_d    = {ADDR_W{1'b0}};
          counter_d = {CNT_W{1'b0}};
          period_d  = period_new_s;
        end else begin
          addr_d    = addr_q;
        end
      end
      ST_RUN, ST_PAUSE: begin
        if (stop_i) begin
          addr_d    = {ADDR_W{1'b0}};
          counter_d = {CNT_W{1'b0}};
        end else if (pause_i) begin
          counter_d = counter_q;
        end else if (at_end_s) begin
          counter_d = {CNT_W{1'b0}};
          period_d  = period_new_s;
          tick_d    = 1'b1;
          if (!last_s) begin
            addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          end else if (loop_en_i) begin
            addr_d = {ADDR_W{1'b0}};
          end else begin
            done_d = 1'b1;
          end
        end else begin
          counter_d = counter_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        addr_d    = {ADDR_W{1'b0}};
        counter_d = {CNT_W{1'b0}};
      end
    endcase
    busy_d   = (state_d != ST_IDLE);
    paused_d = (state_d == ST_PAUSE);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      counter_q <= {CNT_W{1'b0}};
      period_q  <= DIV_BASE_C;
      addr_q    <= {ADDR_W{1'b0}};
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      counter_q <= counter_d;
      period_q  <= period_d;
      addr_q    <= addr_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      paused_q  <= paused_d;
    end
  end

  assign addr_o   = addr_q;
  assign tick_o   = tick_q;
  assign done_o   = done_q;
  assign busy_o   = busy_q;
  assign paused_o = paused_q;

endmodule

// File: tb/tb_addr_seq_ctrl.sv
// Directed bench for addr_seq_ctrl (DIV_BASE=4, ADDR_MAX=3); tick/done events
// are scored against a queue of expected (edge, addr, done, busy) entries.
module tb_addr_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_i = 1'b0;
  logic       stop_i = 1'b0;
  logic       pause_i = 1'b0;
  logic       loop_en_i = 1'b0;
  logic [1:0] speed_sel_i = 2'd0;
  logic [7:0] addr_o;
  logic       tick_o, busy_o, paused_o, done_o;

  typedef struct {
    int         edge_n;
    logic [7:0] addr;
    logic       done;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;

  addr_seq_ctrl #(
    .ADDR_W  (8),
    .ADDR_MAX(8'd3),
    .DIV_BASE(25'd4),
    .CNT_W   (28)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .pause_i    (pause_i),
    .loop_en_i  (loop_en_i),
    .speed_sel_i(speed_sel_i),
    .addr_o     (addr_o),
    .tick_o     (tick_o),
    .busy_o     (busy_o),
    .paused_o   (paused_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int e, input logic [7:0] a, input logic d, input logic b);
    exp_t x;
    x.edge_n = e;
    x.addr   = a;
    x.done   = d;
    x.busy   = b;
    exp_q.push_back(x);
  endtask

  // One clock edge, sampled 1 time unit later; any tick/done is scored.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    edge_n++;
    if ((tick_o !== 1'b0) || (done_o !== 1'b0)) begin
      if (exp_q.size() == 0) begin
        chk("spurious_tick", {30'd0, tick_o, done_o}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("tick_edge", edge_n, e.edge_n);
        chk("tick_flag", {31'd0, tick_o}, 32'd1);
        chk("tick_addr", {24'd0, addr_o}, {24'd0, e.addr});
        chk("tick_done", {31'd0, done_o}, {31'd0, e.done});
        chk("tick_busy", {31'd0, busy_o}, {31'd0, e.busy});
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      step();
    end
  endtask

  task automatic drain(input string tag);
    chk(tag, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic start_seq();
    edge_n  = -1;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"}, {24'd0, addr_o}, 32'd0);
    chk({tag, "_tick"}, {31'd0, tick_o}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "_paused"}, {31'd0, paused_o}, 32'd0);
    chk({tag, "_done"}, {31'd0, done_o}, 32'd0);
  endtask

  initial begin
    // Reset with random inputs, checked before any clock edge.
    #1;
    start_i     = 1'($urandom);
    stop_i      = 1'($urandom);
    pause_i     = 1'($urandom);
    loop_en_i   = 1'($urandom);
    speed_sel_i = 2'($urandom);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst0");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    start_i = 1'b0; stop_i = 1'b0; pause_i = 1'b0; loop_en_i = 1'b0; speed_sel_i = 2'd0;

    // Single pass, no loop.
    push(4, 8'd1, 1'b0, 1'b1);
    push(8, 8'd2, 1'b0, 1'b1);
    push(12, 8'd3, 1'b0, 1'b1);
    push(16, 8'd3, 1'b1, 1'b0);
    start_seq();
    chk("s2_busy_e0", {31'd0, busy_o}, 32'd1);
    chk("s2_addr_e0", {24'd0, addr_o}, 32'd0);
    steps(24);
    drain("s2_drain");
    chk("s2_busy_end", {31'd0, busy_o}, 32'd0);
    chk("s2_addr_end", {24'd0, addr_o}, 32'd3);

    // Loop wrap 3 -> 0, then async reset mid-sequence.
    loop_en_i = 1'b1;
    push(4, 8'd1, 1'b0, 1'b1);
    push(8, 8'd2, 1'b0, 1'b1);
    push(12, 8'd3, 1'b0, 1'b1);
    push(16, 8'd0, 1'b0, 1'b1);
    push(20, 8'd1, 1'b0, 1'b1);
    start_seq();
    steps(21);
    drain("s3_drain");
    chk("s3_busy_pre_rst", {31'd0, busy_o}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Speed change takes effect at the next step boundary.
    loop_en_i = 1'b0;
    push(4, 8'd1, 1'b0, 1'b1);
    push(8, 8'd2, 1'b0, 1'b1);
    push(24, 8'd3, 1'b0, 1'b1);
    push(40, 8'd3, 1'b1, 1'b0);
    start_seq();
    steps(5);
    speed_sel_i = 2'd2;
    steps(39);
    drain("s4_drain");
    chk("s4_busy_end", {31'd0, busy_o}, 32'd0);
    speed_sel_i = 2'd0;

    // Pause for 10 cycles from edge 2; start during pause ignored.
    loop_en_i = 1'b1;
    push(14, 8'd1, 1'b0, 1'b1);
    push(18, 8'd2, 1'b0, 1'b1);
    push(22, 8'd3, 1'b0, 1'b1);
    start_seq();
    step();
    pause_i = 1'b1;
    step();
    chk("s5_paused_e2", {31'd0, paused_o}, 32'd1);
    chk("s5_busy_e2", {31'd0, busy_o}, 32'd1);
    chk("s5_addr_e2", {24'd0, addr_o}, 32'd0);
    steps(2);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("s5_paused_e5", {31'd0, paused_o}, 32'd1);
    chk("s5_addr_e5", {24'd0, addr_o}, 32'd0);
    steps(6);
    pause_i = 1'b0;
    step();
    chk("s5_paused_e12", {31'd0, paused_o}, 32'd0);
    chk("s5_busy_e12", {31'd0, busy_o}, 32'd1);
    steps(11);
    drain("s5_drain");
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    chk("s5_stop_busy", {31'd0, busy_o}, 32'd0);
    chk("s5_stop_addr", {24'd0, addr_o}, 32'd0);
    chk("s5_stop_paused", {31'd0, paused_o}, 32'd0);

    // Stop on the edge a tick is due, then restart; later pause on a tick edge.
    loop_en_i = 1'b0;
    push(4, 8'd1, 1'b0, 1'b1);
    start_seq();
    steps(7);
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    chk("s6_stop_tick", {31'd0, tick_o}, 32'd0);
    chk("s6_stop_addr", {24'd0, addr_o}, 32'd0);
    chk("s6_stop_busy", {31'd0, busy_o}, 32'd0);
    drain("s6_drain_a");
    steps(3);
    push(4, 8'd1, 1'b0, 1'b1);
    push(11, 8'd2, 1'b0, 1'b1);
    start_seq();
    chk("s6_restart_addr", {24'd0, addr_o}, 32'd0);
    chk("s6_restart_busy", {31'd0, busy_o}, 32'd1);
    steps(7);
    pause_i = 1'b1;
    step();
    chk("s6_pause_tick", {31'd0, tick_o}, 32'd0);
    chk("s6_pause_paused", {31'd0, paused_o}, 32'd1);
    steps(2);
    pause_i = 1'b0;
    step();
    chk("s6_resume_paused", {31'd0, paused_o}, 32'd0);
    drain("s6_drain_b");
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    chk("s6_final_busy", {31'd0, busy_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
